// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared fetch-stage types, constants and helpers
package core_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;
  localparam int          PAIR_BYTES = 8;

  function automatic logic [31:0] pair_align(input logic [31:0] addr);
    return {addr[31:3], 3'b000};
  endfunction

endpackage

// File: rtl/fetch_unit_next_pc_sel.sv
// rtl/fetch_unit_next_pc_sel.sv - next-PC priority mux; predictor path enabled by FETCH_BP_EN
module next_pc_sel
  import core_pkg::*;
(
  input  logic [31:0] pc,
  input  logic        rsp_valid,
  input  logic        fetch_valid,
  input  logic        out_ready,
  input  logic        bp_take,
  input  logic [31:0] bp_target,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] next_pc
);

  logic        bp_hit;
  logic [31:0] seq_pc;

`ifdef FETCH_BP_EN
  assign bp_hit = fetch_valid & bp_take;
`else
  logic unused_bp;
  assign unused_bp = ^{bp_take, bp_target};
  assign bp_hit    = 1'b0;
`endif

  // Sequential flow always lands on the next aligned pair, dropping bit 2.
  assign seq_pc = pair_align(pc) + 32'(PAIR_BYTES);

  always_comb begin
    next_pc = seq_pc;
    if (redirect_valid) begin
      next_pc = redirect_pc;
    end else if (fetch_valid && !out_ready) begin
      next_pc = pc;
    end else if (bp_hit) begin
`ifdef FETCH_BP_EN
      next_pc = bp_target;
`else
      next_pc = seq_pc;
`endif
    end else if (!rsp_valid) begin
      next_pc = pc;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage feeding predictor and decode; FETCH_BP_EN enables predictor redirects
module fetch_unit
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  output logic        imem_req,
  input  logic        imem_gnt,
  input  logic [63:0] imem_rdata,
  output logic [31:0] instruction_low,
  output logic [31:0] instruction_high,
  output logic [31:0] delayed_pc,
  output logic        delayed_pc2,
  output logic        fetch_valid,
  input  logic        out_ready,
  input  logic        bp_take,
  input  logic [31:0] bp_target,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         rsp_valid_q, rsp_valid_d;
  logic [31:0]  next_pc;

  // Request is live from the first cycle out of reset so BOOT issues RESET_PC.
  assign imem_req    = rst_n;
  assign fetch_valid = rsp_valid_q & (state_q != BOOT);

  assign delayed_pc       = pair_align(pc_q);
  assign delayed_pc2      = pc_q[2];
  assign imem_addr        = pair_align(next_pc);
  assign instruction_low  = fetch_valid ? imem_rdata[31:0]  : NOP_INSTR;
  assign instruction_high = fetch_valid ? imem_rdata[63:32] : NOP_INSTR;

  next_pc_sel u_next_pc_sel (
    .pc             (pc_q),
    .rsp_valid      (rsp_valid_q),
    .fetch_valid    (fetch_valid),
    .out_ready      (out_ready),
    .bp_take        (bp_take),
    .bp_target      (bp_target),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .next_pc        (next_pc)
  );

  always_comb begin
    pc_d        = next_pc;
    rsp_valid_d = imem_req & imem_gnt;
    state_d     = state_q;
    case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        if (!redirect_valid && fetch_valid && !out_ready) state_d = HOLD;
      end
      HOLD: begin
        if (redirect_valid || out_ready) state_d = RUN;
      end
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= BOOT;
      pc_q        <= RESET_PC;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - table-driven bench with pair scoreboard for fetch_unit
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef FETCH_BP_EN
  localparam bit BP = 1'b1;
`else
  localparam bit BP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] imem_addr;
  logic        imem_req;
  logic        imem_gnt = 1'b1;
  logic [63:0] imem_rdata = 64'h0;
  logic [31:0] instruction_low, instruction_high, delayed_pc;
  logic        delayed_pc2, fetch_valid;
  logic        out_ready = 1'b1;
  logic        bp_take = 1'b0;
  logic [31:0] bp_target = 32'h0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;

  int checks = 0;
  int errors = 0;

  fetch_unit #(.RESET_PC(32'h0000_1000)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .imem_addr        (imem_addr),
    .imem_req         (imem_req),
    .imem_gnt         (imem_gnt),
    .imem_rdata       (imem_rdata),
    .instruction_low  (instruction_low),
    .instruction_high (instruction_high),
    .delayed_pc       (delayed_pc),
    .delayed_pc2      (delayed_pc2),
    .fetch_valid      (fetch_valid),
    .out_ready        (out_ready),
    .bp_take          (bp_take),
    .bp_target        (bp_target),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mword(input logic [31:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h0013_0000;
  endfunction

  // Synchronous memory: granted address returns its pair on the next cycle.
  always @(posedge clk) begin
    if (imem_req && imem_gnt) imem_rdata <= {mword(imem_addr + 32'd4), mword(imem_addr)};
  end

  typedef struct {
    logic        gnt, rdy, bp, rd;
    logic [31:0] bpt, rdpc, addr;
    logic        valid;
    logic [31:0] dpc;
    logic        dpc2;
  } vec_t;

  typedef struct {
    logic [31:0] dpc;
    logic [63:0] data;
  } sb_t;

  vec_t vecs[$];
  sb_t  sbq[$];

  function automatic vec_t mk(logic gnt, logic rdy, logic bp, logic [31:0] bpt, logic rd,
                              logic [31:0] rdpc, logic [31:0] addr, logic valid,
                              logic [31:0] dpc, logic dpc2);
    vec_t v;
    v.gnt = gnt; v.rdy = rdy; v.bp = bp; v.bpt = bpt; v.rd = rd; v.rdpc = rdpc;
    v.addr = addr; v.valid = valid; v.dpc = dpc; v.dpc2 = dpc2;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_pair(input string tag);
    sb_t e;
    if (fetch_valid) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL %s sb_empty: got valid pair expected none", tag);
      end else begin
        e = sbq.pop_front();
        chk({tag, " sb_dpc"}, delayed_pc, e.dpc);
        chk({tag, " sb_low"}, instruction_low, e.data[31:0]);
        chk({tag, " sb_high"}, instruction_high, e.data[63:32]);
      end
    end else begin
      chk({tag, " nop_low"}, instruction_low, NOP);
      chk({tag, " nop_high"}, instruction_high, NOP);
    end
  endtask

  task automatic push_expected(input logic [31:0] addr);
    sb_t e;
    e.dpc  = addr;
    e.data = {mword(addr + 32'd4), mword(addr)};
    sbq.push_back(e);
  endtask

  initial begin
    vec_t v;
    string tag;

    //              gnt rdy bp bpt           rd rdpc          addr          v  dpc           dpc2
    vecs.push_back(mk(1, 1, 0, 32'h0,        0, 32'h0,        32'h1000,     0, 32'h1000,     0));
    vecs.push_back(mk(1, 1, 0, 32'h0,        0, 32'h0,        32'h1008,     1, 32'h1000,     0));
    vecs.push_back(mk(1, 1, 0, 32'h0,        0, 32'h0,        32'h1010,     1, 32'h1008,     0));
    vecs.push_back(mk(1, 0, 0, 32'h0,        0, 32'h0,        32'h1010,     1, 32'h1010,     0));
    vecs.push_back(mk(1, 0, 1, 32'h4000,     0, 32'h0,        32'h1010,     1, 32'h1010,     0));
    vecs.push_back(mk(1, 0, 0, 32'h0,        0, 32'h0,        32'h1010,     1, 32'h1010,     0));
    vecs.push_back(mk(1, 1, 0, 32'h0,        0, 32'h0,        32'h1018,     1, 32'h1010,     0));
    vecs.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,        32'h1020,     1, 32'h1018,     0));
    vecs.push_back(mk(0, 1, 1, 32'h5000,     0, 32'h0,        32'h1020,     0, 32'h1020,     0));
    vecs.push_back(mk(1, 1, 0, 32'h0,        0, 32'h0,        32'h1020,     0, 32'h1020,     0));
    vecs.push_back(mk(1, 1, 0, 32'h0,        0, 32'h0,        32'h1028,     1, 32'h1020,     0));
    vecs.push_back(mk(1, 0, 0, 32'h0,        0, 32'h0,        32'h1028,     1, 32'h1028,     0));
    vecs.push_back(mk(1, 0, 1, 32'h3000,     1, 32'h2000,     32'h2000,     1, 32'h1028,     0));
    vecs.push_back(mk(1, 1, 0, 32'h0,        0, 32'h0,        32'h2008,     1, 32'h2000,     0));
    vecs.push_back(mk(1, 1, 1, 32'h0FEC,     0, 32'h0,        BP ? 32'h0FE8 : 32'h2010, 1, 32'h2008, 0));
    vecs.push_back(mk(1, 1, 0, 32'h0,        0, 32'h0,        BP ? 32'h0FF0 : 32'h2018, 1,
                      BP ? 32'h0FE8 : 32'h2010, BP));
    vecs.push_back(mk(1, 1, 0, 32'h0,        0, 32'h0,        BP ? 32'h0FF8 : 32'h2020, 1,
                      BP ? 32'h0FF0 : 32'h2018, 0));
    vecs.push_back(mk(1, 1, 0, 32'h0,        1, 32'h3004,     32'h3000,     1,
                      BP ? 32'h0FF8 : 32'h2020, 0));
    vecs.push_back(mk(1, 1, 0, 32'h0,        0, 32'h0,        32'h3008,     1, 32'h3000,     1));
    vecs.push_back(mk(1, 1, 0, 32'h0,        1, 32'hFFFF_FFF8, 32'hFFFF_FFF8, 1, 32'h3008,    0));
    vecs.push_back(mk(1, 1, 0, 32'h0,        0, 32'h0,        32'h0000_0000, 1, 32'hFFFF_FFF8, 0));
    vecs.push_back(mk(1, 1, 0, 32'h0,        0, 32'h0,        32'h0000_0008, 1, 32'h0000_0000, 0));

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_valid", {31'd0, fetch_valid}, 32'd0);
    chk("rst_dpc", delayed_pc, 32'h1000);
    chk("rst_dpc2", {31'd0, delayed_pc2}, 32'd0);
    chk("rst_addr", imem_addr, 32'h1000);
    chk("rst_low", instruction_low, NOP);
    chk("rst_high", instruction_high, NOP);

    @(posedge clk);
    #2 rst_n = 1'b1;

    foreach (vecs[i]) begin
      v = vecs[i];
      @(negedge clk);
      imem_gnt       = v.gnt;
      out_ready      = v.rdy;
      bp_take        = v.bp;
      bp_target      = v.bpt;
      redirect_valid = v.rd;
      redirect_pc    = v.rdpc;
      #1;
      tag = $sformatf("c%0d", i);
      chk({tag, " addr"}, imem_addr, v.addr);
      chk({tag, " valid"}, {31'd0, fetch_valid}, {31'd0, v.valid});
      chk({tag, " dpc"}, delayed_pc, v.dpc);
      chk({tag, " dpc2"}, {31'd0, delayed_pc2}, {31'd0, v.dpc2});
      chk({tag, " req"}, {31'd0, imem_req}, 32'd1);
      check_pair(tag);
      if (v.gnt) push_expected(v.addr);
    end

    // Mid-operation asynchronous reset with a granted pair in flight
    @(negedge clk);
    imem_gnt = 1'b1; out_ready = 1'b1; bp_take = 1'b0; redirect_valid = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    sbq.delete();
    chk("mid_rst_req", {31'd0, imem_req}, 32'd0);
    chk("mid_rst_valid", {31'd0, fetch_valid}, 32'd0);
    chk("mid_rst_dpc", delayed_pc, 32'h1000);
    chk("mid_rst_low", instruction_low, NOP);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk("boot_valid", {31'd0, fetch_valid}, 32'd0);
    chk("boot_addr", imem_addr, 32'h1000);
    chk("boot_req", {31'd0, imem_req}, 32'd1);
    check_pair("boot");
    push_expected(32'h1000);
    @(negedge clk);
    #1;
    chk("first_valid", {31'd0, fetch_valid}, 32'd1);
    chk("first_addr", imem_addr, 32'h1008);
    check_pair("first");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
